// File: rtl/mux_nc_reg.sv
// N-input WIDTH-bit selector with a single registered output slot and a valid/ready
// handshake. Channel choice is either fixed by Ctrl or round-robin among valid inputs.
module mux_nc_reg #(
  parameter int WIDTH  = 5,
  parameter int N_ENT  = 4,
  parameter int CTRL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CTRL_W-1:0]      Ctrl,
  input  logic                   Modo,
  input  logic [N_ENT*WIDTH-1:0] Entradas,
  input  logic [N_ENT-1:0]       Valido_In,
  input  logic                   Listo_Out,
  output logic [N_ENT-1:0]       Ack,
  output logic [WIDTH-1:0]       Mux_Out,
  output logic                   Valido_Out,
  output logic [CTRL_W-1:0]      Sel_Out,
  output logic                   Error
);

  // Handshake: a channel's word is consumed in the cycle its Ack bit is high
  // (Valido_In[i] && Ack[i]); the output word is taken downstream on any edge
  // where Valido_Out && Listo_Out. Ack is only raised when the slot is free.

  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic [CTRL_W-1:0] r_sel;
  logic              r_error;
  logic [CTRL_W-1:0] r_ptr;

  logic              w_ctrl_ok;
  logic              w_fix_vld;
  logic              w_rr_vld;
  logic [CTRL_W-1:0] w_rr_idx;
  logic              w_grant_vld;
  logic [CTRL_W-1:0] w_grant_idx;
  logic              w_slot_free;
  logic              w_load;
  logic [WIDTH-1:0]  w_data;
  logic [CTRL_W-1:0] w_ptr_next;

  assign w_ctrl_ok = ({{(32-CTRL_W){1'b0}}, Ctrl} < 32'(N_ENT));

  // Fixed-mode grant: the addressed channel must exist and be valid.
  always_comb begin
    w_fix_vld = 1'b0;
    for (int i = 0; i < N_ENT; i++) begin
      if (Ctrl == CTRL_W'(i) && Valido_In[i]) w_fix_vld = 1'b1;
    end
  end

  // Round-robin search starting at r_ptr, wrapping modulo N_ENT.
  always_comb begin
    int idx;
    logic v;
    w_rr_vld = 1'b0;
    w_rr_idx = '0;
    idx      = 0;
    v        = 1'b0;
    for (int k = 0; k < N_ENT; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N_ENT) idx = idx - N_ENT;
      v = 1'b0;
      for (int i = 0; i < N_ENT; i++) begin
        if (i == idx) v = Valido_In[i];
      end
      if (!w_rr_vld && v) begin
        w_rr_vld = 1'b1;
        w_rr_idx = CTRL_W'(idx);
      end
    end
  end

  assign w_grant_vld = Modo ? w_rr_vld : w_fix_vld;
  assign w_grant_idx = Modo ? w_rr_idx : Ctrl;
  assign w_slot_free = !r_valid || Listo_Out;
  assign w_load      = w_slot_free && w_grant_vld && !rst;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (w_grant_idx == CTRL_W'(i)) w_data = Entradas[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    Ack = '0;
    for (int i = 0; i < N_ENT; i++) begin
      Ack[i] = w_load && (w_grant_idx == CTRL_W'(i));
    end
  end

  assign w_ptr_next = (w_grant_idx == CTRL_W'(N_ENT - 1)) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_error <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_error <= !Modo && !w_ctrl_ok;
      if (w_slot_free) begin
        if (w_grant_vld) begin
          r_data  <= w_data;
          r_sel   <= w_grant_idx;
          r_valid <= 1'b1;
          if (Modo) r_ptr <= w_ptr_next;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign Mux_Out    = r_data;
  assign Valido_Out = r_valid;
  assign Sel_Out    = r_sel;
  assign Error      = r_error;

endmodule

// File: tb/tb_mux_nc_reg.sv
// Bench for mux_nc_reg (N_ENT=3, WIDTH=5): directed scenarios plus random traffic,
// checked against a behavioural model of the output slot and an accepted-word queue.
module tb_mux_nc_reg;
  localparam int W  = 5;
  localparam int N  = 3;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [CW-1:0]  ctrl;
  logic           modo;
  logic [N*W-1:0] ent;
  logic [N-1:0]   vin;
  logic           listo;
  logic [N-1:0]   ack;
  logic [W-1:0]   mux_out;
  logic           vout;
  logic [CW-1:0]  sel_out;
  logic           err;

  int n_cmp = 0;
  int n_err = 0;

  int m_valid, m_data, m_sel, m_err, m_ptr;
  logic [W-1:0] exp_q[$];

  mux_nc_reg #(.WIDTH(W), .N_ENT(N), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .Ctrl(ctrl), .Modo(modo), .Entradas(ent),
    .Valido_In(vin), .Listo_Out(listo), .Ack(ack), .Mux_Out(mux_out),
    .Valido_Out(vout), .Sel_Out(sel_out), .Error(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winning channel under the block's rules, or -1 when nothing can be granted.
  function automatic int pred_grant(input int md, input int c, input int v);
    if (md == 0) begin
      if (c < N && ((v >> c) & 1) == 1) return c;
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int ch;
      ch = (m_ptr + k) % N;
      if (((v >> ch) & 1) == 1) return ch;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic md, input logic [CW-1:0] c,
                       input logic [N-1:0] v, input logic l);
    int g, free, ld;
    logic [W-1:0] w;
    rst = r; modo = md; ctrl = c; vin = v; listo = l;
    @(negedge clk);
    g    = r ? -1 : pred_grant(int'(md), int'(c), int'(v));
    free = (m_valid == 0 || l) ? 1 : 0;
    ld   = (free == 1 && g >= 0) ? 1 : 0;
    chk("ack",   int'(ack), ld ? (1 << g) : 0);
    chk("mux",   int'(mux_out), m_data);
    chk("vout",  int'(vout), m_valid);
    chk("sel",   int'(sel_out), m_sel);
    chk("error", int'(err), m_err);
    if (!r && vout && l) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_word", int'(mux_out), int'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_err = 0; m_ptr = 0;
      exp_q.delete();
    end else begin
      m_err = (md == 1'b0 && int'(c) >= N) ? 1 : 0;
      if (free == 1) begin
        if (ld == 1) begin
          w = ent[g*W +: W];
          if (m_valid == 1) void'(exp_q.size());
          m_data = int'(w); m_sel = g; m_valid = 1;
          if (md) m_ptr = (g + 1) % N;
          exp_q.push_back(w);
        end else begin
          m_valid = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; modo = 1'b0; ctrl = '0; vin = '0; listo = 1'b1;
    ent = {5'd3, 5'd2, 5'd1};
    m_valid = 0; m_data = 0; m_sel = 0; m_err = 0; m_ptr = 0;
    @(posedge clk); #1;
    cycle(1, 0, 0, 3'b000, 1);
    chk("rst_vout", int'(vout), 0);
    chk("rst_mux", int'(mux_out), 0);

    // Fixed-mode selection of each channel
    cycle(0, 0, 0, 3'b111, 1); chk("p1_mux0", int'(mux_out), 1);
    cycle(0, 0, 1, 3'b111, 1); chk("p1_mux1", int'(mux_out), 2);
    cycle(0, 0, 2, 3'b111, 1); chk("p1_mux2", int'(mux_out), 3);
    chk("p1_sel2", int'(sel_out), 2);

    // Out-of-range Ctrl, then recovery
    cycle(0, 0, 3, 3'b111, 1); chk("p2_err", int'(err), 1); chk("p2_vout", int'(vout), 0);
    cycle(0, 0, 1, 3'b111, 1); chk("p2_err0", int'(err), 0); chk("p2_mux", int'(mux_out), 2);

    // Round-robin rotation from a fresh reset
    cycle(1, 1, 0, 3'b111, 1);
    cycle(0, 1, 0, 3'b111, 1); chk("p3_sel_a", int'(sel_out), 0);
    cycle(0, 1, 0, 3'b111, 1); chk("p3_sel_b", int'(sel_out), 1);
    cycle(0, 1, 0, 3'b111, 1); chk("p3_sel_c", int'(sel_out), 2);
    cycle(0, 1, 0, 3'b111, 1); chk("p3_sel_d", int'(sel_out), 0);
    cycle(0, 1, 0, 3'b100, 1); chk("p3_only2", int'(sel_out), 2);
    cycle(0, 1, 0, 3'b100, 1); chk("p3_only2b", int'(sel_out), 2);
    cycle(0, 1, 0, 3'b111, 1); chk("p3_ptr0", int'(sel_out), 0);

    // Stall holds the slot
    cycle(0, 0, 1, 3'b111, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 2, 3'b111, 0);
      chk("p4_hold_mux", int'(mux_out), 2);
      chk("p4_hold_vld", int'(vout), 1);
    end
    cycle(0, 0, 2, 3'b111, 1); chk("p4_release", int'(mux_out), 3);

    // Reset mid-operation with pointer at 2
    cycle(1, 1, 0, 3'b111, 1);
    cycle(0, 1, 0, 3'b111, 1);
    cycle(0, 1, 0, 3'b111, 1);
    cycle(0, 0, 2, 3'b111, 1); chk("p5_pre_mux", int'(mux_out), 3);
    cycle(1, 1, 0, 3'b111, 1);
    chk("p5_mux", int'(mux_out), 0); chk("p5_sel", int'(sel_out), 0);
    chk("p5_vout", int'(vout), 0);
    cycle(0, 1, 0, 3'b111, 1); chk("p5_first", int'(sel_out), 0);

    // No valid inputs in either mode
    cycle(0, 1, 0, 3'b000, 1); chk("p6_vout_rr", int'(vout), 0);
    cycle(0, 0, 1, 3'b011, 1);
    cycle(0, 0, 1, 3'b000, 1); chk("p6_vout_fx", int'(vout), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ent = N*W'($urandom());
      cycle(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            CW'($urandom_range(0, 3)), N'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
